accu_result_fifo: RTL and testbench
===================================

# accu_result_fifo

Downstream buffer for the accumulator stage. Captures each 10-bit group sum on the accumulator's single-cycle result strobe, queues it in a small FIFO, and presents it on a valid/ready output with a derived 8-bit mean (sum/4). Decouples the accumulator, which cannot be stalled, from a consumer that may backpressure. Reports overflow and occupancy.

## Interface
- DEPTH, 4: FIFO entries; power of two, at least 2.
- SUM_W, 10: width of the accumulator sum (4 × 8-bit inputs).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sum_in  in  SUM_W  accumulator result (its data_out).
- sum_valid  in  1  one-cycle result strobe (accumulator valid_out).
- out_sum  out  SUM_W  head-of-queue sum.
- out_mean  out  SUM_W-2  out_sum >> 2 (truncating).
- out_valid  out  1  queue non-empty.
- out_ready  in  1  consumer accepts head this cycle.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a result was dropped.
- clr_ovf  in  1  synchronous clear of overflow.

## Operation
- Push = sum_valid. Pop = out_valid && out_ready.
- First-word-fall-through: out_sum/out_mean are driven from storage at rd_ptr. Both are 0 whenever the queue is empty.
- Push when count < DEPTH: write at wr_ptr, advance wr_ptr, count+1.
- Push when full and no pop: the value is dropped and storage is unchanged. overflow is set on the next edge.
- Push and pop in the same cycle:
  - Count is unchanged and both pointers advance.
  - This is legal when full; the new value is accepted.
  - It is illegal when empty, because there is no pop; this case is a plain push.
- Pointers have log2(DEPTH) bits and wrap modulo DEPTH.
- count is a registered counter, not derived from the pointers.
- out_ready asserted while empty has no effect.
- clr_ovf clears overflow. If clr_ovf and a new drop occur in the same cycle, the set wins.
- out_mean = out_sum[SUM_W-1:2]. Maximum input 1020 gives mean 255.

## Timing
- Reset (async assert, sync release) sets pointers = 0, count = 0, out_valid = 0, out_sum = 0, out_mean = 0, overflow = 0. Storage contents do not matter.
- A reset mid-operation discards all queued entries immediately.
- Latency: a push at edge N makes out_valid = 1 and the data visible after edge N. The consumer can pop at edge N+1.
- The out_sum value must stay stable while out_valid = 1 and out_ready = 0.
- Throughput: one push and one pop per cycle, sustained.
- The accumulator issues at most one sum_valid per 4 input beats. The FIFO does not rely on this and handles sum_valid on every cycle.

## Structure
- Add to the shared accu_pkg package:
  - localparam SUM_W = 10;
  - localparam MEAN_W = SUM_W - 2;
  - typedef logic [SUM_W-1:0] accu_sum_t.
- There is one natural sub-module, accu_fifo_mem: a DEPTH × SUM_W register array with a synchronous write port and an asynchronous read port, no reset on storage.
- Pointer, count, and flag logic live in accu_result_fifo.

## Test plan
- Reset, then push 40 with out_ready = 0 → out_valid = 1 after the edge, out_sum = 40, out_mean = 10, count = 1.
- Push 100, 200, 300, 1020 with out_ready = 0 → count = 4. Then hold out_ready = 1 → outputs come out in order with means 25, 50, 75, 255, then out_valid = 0 and out_sum = 0.
- Full (4 entries), push 7 with no pop → count stays 4 and overflow = 1. Drain → the 7 never appears. Pulse clr_ovf → overflow = 0.
- Full, push 9 with out_ready = 1 in the same cycle → count stays 4, the head pops, and 9 is the last entry drained.
- Continuous push of 1, 2, 3, … for 12 cycles with out_ready = 1 → outputs 1..12 in order, count ≤ 1, pointers wrap with no loss and no overflow.
- Push 3 entries, assert rst_n = 0 between clock edges → out_valid, count, and out_sum go to 0 at once. After release, push 5 → out_sum = 5, count = 1.

Source files
------------

// File: rtl/accu_pkg.sv
// Shared types and sizes for the accumulator stage and its result buffer.
package accu_pkg;
   localparam int SUM_W  = 10;          // 4 x 8-bit inputs summed
   localparam int MEAN_W = SUM_W - 2;   // sum / 4
   typedef logic [SUM_W-1:0] accu_sum_t;
endpackage

// File: rtl/accu_fifo_mem.sv
// Result FIFO storage: register array, synchronous write, asynchronous read.
// Storage is intentionally not reset; validity is tracked by the owner.
module accu_fifo_mem
   import accu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = SUM_W,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [W-1:0]  wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [W-1:0]  rdata_o
);

   logic [W-1:0] mem_q [DEPTH];

   // Write one entry per cycle when enabled.
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/accu_result_fifo.sv
// Buffers accumulator group sums behind a valid/ready port so the
// accumulator never stalls. First-word-fall-through; a push into a full
// queue without a simultaneous pop is dropped and flagged (sticky).
module accu_result_fifo
   import accu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int SUM_W = accu_pkg::SUM_W
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [SUM_W-1:0]           sum_in,
   input  logic                       sum_valid,
   output logic [SUM_W-1:0]           out_sum,
   output logic [SUM_W-3:0]           out_mean,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   input  logic                       clr_ovf
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             push, pop, full, wr_en;
   logic [SUM_W-1:0] rdata;

   assign push      = sum_valid;
   assign out_valid = (count_q != '0);
   assign pop       = out_valid && out_ready;
   assign full      = (count_q == CNT_W'(DEPTH));
   // A full queue still accepts when the head leaves in the same cycle.
   assign wr_en     = push && (!full || pop);

   accu_fifo_mem #(
      .DEPTH (DEPTH),
      .W     (SUM_W)
   ) u_mem (
      .clk     (clk),
      .we_i    (wr_en),
      .waddr_i (wr_ptr_q),
      .wdata_i (sum_in),
      .raddr_i (rd_ptr_q),
      .rdata_o (rdata)
   );

   // Next-state for pointers, occupancy and the sticky drop flag.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;   // wraps modulo DEPTH
      if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_en, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      // A new drop takes priority over a clear in the same cycle.
      if (clr_ovf)                ovf_d = 1'b0;
      if (push && full && !pop)   ovf_d = 1'b1;
   end

   // State registers; reset discards every queued entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // Head is forced to zero while empty so stale storage never leaks out.
   assign out_sum  = out_valid ? rdata : '0;
   assign out_mean = out_sum[SUM_W-1:2];
   assign count    = count_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_accu_result_fifo.sv
// Directed bench for accu_result_fifo with hand-computed expectations.
module tb_accu_result_fifo;
   import accu_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   accu_sum_t  sum_in;
   logic       sum_valid;
   accu_sum_t  out_sum;
   logic [MEAN_W-1:0] out_mean;
   logic       out_valid;
   logic       out_ready;
   logic [2:0] count;
   logic       overflow;
   logic       clr_ovf;

   int n_tests = 0;
   int n_fail  = 0;

   accu_result_fifo #(.DEPTH(4), .SUM_W(10)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sum_in    (sum_in),
      .sum_valid (sum_valid),
      .out_sum   (out_sum),
      .out_mean  (out_mean),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .count     (count),
      .overflow  (overflow),
      .clr_ovf   (clr_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int want);
      n_tests++;
      if (obs != want) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, want);
      end
   endtask

   // One clock: drive at negedge, take the posedge, return at next negedge.
   task automatic cyc(input logic sv, input int v, input logic rdy, input logic clr);
      sum_valid = sv;
      sum_in    = 10'(v);
      out_ready = rdy;
      clr_ovf   = clr;
      @(posedge clk);
      @(negedge clk);
      sum_valid = 1'b0;
      out_ready = 1'b0;
      clr_ovf   = 1'b0;
   endtask

   // Check head then pop it.
   task automatic pop_chk(input string tag, input int want);
      chk({tag, "_valid"}, int'(out_valid), 1);
      chk({tag, "_sum"},   int'(out_sum),   want);
      chk({tag, "_mean"},  int'(out_mean),  want / 4);
      cyc(1'b0, 0, 1'b1, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; sum_in = '0; sum_valid = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_count", int'(count), 0);
      chk("rst_sum",   int'(out_sum), 0);
      chk("rst_mean",  int'(out_mean), 0);
      chk("rst_ovf",   int'(overflow), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single push becomes visible right after its edge.
      cyc(1'b1, 40, 1'b0, 1'b0);
      chk("p40_valid", int'(out_valid), 1);
      chk("p40_sum",   int'(out_sum), 40);
      chk("p40_mean",  int'(out_mean), 10);
      chk("p40_count", int'(count), 1);
      pop_chk("d40", 40);
      chk("d40_empty", int'(out_valid), 0);

      // Fill to four, hold, then drain in order.
      cyc(1'b1, 100, 1'b0, 1'b0);
      cyc(1'b1, 200, 1'b0, 1'b0);
      cyc(1'b1, 300, 1'b0, 1'b0);
      cyc(1'b1, 1020, 1'b0, 1'b0);
      chk("fill_count", int'(count), 4);
      cyc(1'b0, 0, 1'b0, 1'b0);
      chk("hold_sum", int'(out_sum), 100);
      pop_chk("d100", 100);
      pop_chk("d200", 200);
      pop_chk("d300", 300);
      pop_chk("d1020", 1020);
      chk("drain_valid", int'(out_valid), 0);
      chk("drain_sum",   int'(out_sum), 0);
      chk("drain_mean",  int'(out_mean), 0);
      chk("drain_count", int'(count), 0);

      // Overflow: push into full with no pop is dropped.
      cyc(1'b1, 10, 1'b0, 1'b0);
      cyc(1'b1, 20, 1'b0, 1'b0);
      cyc(1'b1, 30, 1'b0, 1'b0);
      cyc(1'b1, 40, 1'b0, 1'b0);
      chk("ovf_pre", int'(overflow), 0);
      cyc(1'b1, 7, 1'b0, 1'b0);
      chk("ovf_count", int'(count), 4);
      chk("ovf_set",   int'(overflow), 1);
      pop_chk("o10", 10);
      pop_chk("o20", 20);
      pop_chk("o30", 30);
      pop_chk("o40", 40);
      chk("ovf_empty", int'(out_valid), 0);
      chk("ovf_sticky", int'(overflow), 1);
      cyc(1'b0, 0, 1'b0, 1'b1);
      chk("ovf_clr", int'(overflow), 0);

      // Full: drop with clear in same cycle (set wins), then push+pop.
      cyc(1'b1, 11, 1'b0, 1'b0);
      cyc(1'b1, 12, 1'b0, 1'b0);
      cyc(1'b1, 13, 1'b0, 1'b0);
      cyc(1'b1, 14, 1'b0, 1'b0);
      cyc(1'b1, 99, 1'b0, 1'b1);
      chk("setwin_ovf", int'(overflow), 1);
      chk("setwin_count", int'(count), 4);
      cyc(1'b1, 9, 1'b1, 1'b0);
      chk("pp_count", int'(count), 4);
      chk("pp_head",  int'(out_sum), 12);
      pop_chk("f12", 12);
      pop_chk("f13", 13);
      pop_chk("f14", 14);
      pop_chk("f9", 9);
      chk("pp_empty", int'(out_valid), 0);
      cyc(1'b0, 0, 1'b0, 1'b1);
      chk("pp_clr", int'(overflow), 0);

      // Streaming push+pop every cycle; pointers wrap several times.
      for (int i = 1; i <= 12; i++) begin
         cyc(1'b1, i, 1'b1, 1'b0);
         chk($sformatf("str%0d_sum", i), int'(out_sum), i);
         chk($sformatf("str%0d_cnt", i), int'(count), 1);
      end
      cyc(1'b0, 0, 1'b1, 1'b0);
      chk("str_empty", int'(out_valid), 0);
      chk("str_ovf",   int'(overflow), 0);

      // Asynchronous reset mid-cycle flushes the queue immediately.
      cyc(1'b1, 1, 1'b0, 1'b0);
      cyc(1'b1, 2, 1'b0, 1'b0);
      cyc(1'b1, 3, 1'b0, 1'b0);
      chk("arst_pre", int'(count), 3);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", int'(out_valid), 0);
      chk("arst_count", int'(count), 0);
      chk("arst_sum",   int'(out_sum), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      cyc(1'b1, 5, 1'b0, 1'b0);
      chk("post_sum",   int'(out_sum), 5);
      chk("post_count", int'(count), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
